// File: rtl/tinysoc_pkg.sv
// Shared types and constants for the tinysoc boot path.
package tinysoc_pkg;

    localparam int IMEM_ADDR_W = 12;
    localparam int IMEM_DATA_W = 16;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        DONE
    } loaderState_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rxState_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, glitch and framing detection.
module uart_rx
    import tinysoc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dataByte,
    output logic       byteValid,
    output logic       frameErr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

    rxState_t         state;
    logic             rxMeta;
    logic             rxSync;
    logic             rxPrev;
    logic [CNT_W-1:0] clkCnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle-high reset values keep the edge detector from seeing a false start.
            rxMeta    <= 1'b1;
            rxSync    <= 1'b1;
            rxPrev    <= 1'b1;
            state     <= RX_IDLE;
            clkCnt    <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            dataByte  <= '0;
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            rxMeta    <= rx;
            rxSync    <= rxMeta;
            rxPrev    <= rxSync;
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rxPrev && !rxSync) begin
                        state  <= RX_START;
                        clkCnt <= '0;
                    end
                end
                RX_START: begin
                    if (clkCnt == HALF_END) begin
                        clkCnt <= '0;
                        bitIdx <= '0;
                        state  <= rxSync ? RX_IDLE : RX_DATA;
                    end else begin
                        clkCnt <= clkCnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (clkCnt == BIT_END) begin
                        clkCnt   <= '0;
                        shiftReg <= {rxSync, shiftReg[7:1]};
                        bitIdx   <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7) state <= RX_STOP;
                    end else begin
                        clkCnt <= clkCnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (clkCnt == BIT_END) begin
                        clkCnt <= '0;
                        state  <= RX_IDLE;
                        if (rxSync) begin
                            dataByte  <= shiftReg;
                            byteValid <= 1'b1;
                        end else begin
                            frameErr <= 1'b1;
                        end
                    end else begin
                        clkCnt <= clkCnt + CNT_W'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: receives a length-prefixed 16-bit image over UART and writes it to instruction memory.
module uart_loader
    import tinysoc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int MAX_WORDS    = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [IMEM_ADDR_W-1:0] w_addr,
    output logic [IMEM_DATA_W-1:0] din,
    output logic                   w_en,
    output logic                   cpu_rst,
    output logic                   done,
    output logic                   error
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    loaderState_t state;
    logic [15:0]  len;
    logic [12:0]  wordCnt;
    logic [7:0]   rxByte;
    logic         byteValid;
    logic         frameErr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) rxInst (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .dataByte (rxByte),
        .byteValid(byteValid),
        .frameErr (frameErr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LEN_LO;
            len     <= '0;
            wordCnt <= '0;
            din     <= '0;
            w_addr  <= '0;
            w_en    <= 1'b0;
            cpu_rst <= 1'b1;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            w_en <= 1'b0;
            if (w_en) begin
                // Write cycle: advance the counter and decide completion after the strobe.
                wordCnt <= wordCnt + 13'd1;
                if ({3'b000, wordCnt} == len - 16'd1) begin
                    state   <= DONE;
                    cpu_rst <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    state <= DATA_LO;
                end
            end else if (frameErr && state != DONE) begin
                error   <= 1'b1;
                state   <= LEN_LO;
                wordCnt <= '0;
            end else if (byteValid) begin
                case (state)
                    LEN_LO: begin
                        len[7:0] <= rxByte;
                        state    <= LEN_HI;
                    end
                    LEN_HI: begin
                        len[15:8] <= rxByte;
                        if ({rxByte, len[7:0]} == 16'd0) begin
                            state   <= DONE;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                        end else if ({rxByte, len[7:0]} > MAX_LEN) begin
                            error   <= 1'b1;
                            state   <= DONE;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            wordCnt <= '0;
                            state   <= DATA_LO;
                        end
                    end
                    DATA_LO: begin
                        din[7:0] <= rxByte;
                        state    <= DATA_HI;
                    end
                    DATA_HI: begin
                        din[15:8] <= rxByte;
                        w_addr    <= wordCnt[11:0];
                        w_en      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Randomised self-checking bench for uart_loader against a byte-stream image model.
module tb_uart_loader;

    localparam int CPB  = 12;
    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [11:0] w_addr;
    logic [15:0] din;
    logic        w_en;
    logic        cpu_rst;
    logic        done;
    logic        error;

    uart_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_WORDS   (MAXW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .w_addr (w_addr),
        .din    (din),
        .w_en   (w_en),
        .cpu_rst(cpu_rst),
        .done   (done),
        .error  (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    int         vectors     = 0;
    int         miscompares = 0;
    wr_t        expQ[$];
    logic [7:0] txBytes[$];
    bit         txOk[$];
    bit         expErr;
    bit         expDone;
    logic       prevWen = 1'b0;

    function automatic void check(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Image model: walk the received byte stream since reset and derive the writes.
    task automatic runModel();
        int         pos = 0;
        int         len = 0;
        logic [7:0] lo  = 8'h00;
        bit         fin = 1'b0;
        expQ.delete();
        expErr = 1'b0;
        foreach (txBytes[i]) begin
            if (fin) continue;
            if (!txOk[i]) begin
                expErr = 1'b1;
                pos    = 0;
                continue;
            end
            if (pos == 0) begin
                len = int'(txBytes[i]);
            end else if (pos == 1) begin
                len = len + 256 * int'(txBytes[i]);
                if (len == 0) fin = 1'b1;
                else if (len > MAXW) begin
                    expErr = 1'b1;
                    fin    = 1'b1;
                end
            end else if (pos % 2 == 0) begin
                lo = txBytes[i];
            end else begin
                int w;
                w = (pos - 2) / 2;
                expQ.push_back('{w, {txBytes[i], lo}});
                if (w == len - 1) fin = 1'b1;
            end
            pos++;
        end
        expDone = fin;
    endtask

    task automatic addByte(input logic [7:0] b, input bit ok);
        txBytes.push_back(b);
        txOk.push_back(ok);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB / 2 + $urandom_range(0, CPB)) @(negedge clk);
    endtask

    task automatic sendStream();
        foreach (txBytes[i]) sendByte(txBytes[i], txOk[i]);
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        txBytes.delete();
        txOk.delete();
        expQ.delete();
        expErr  = 1'b0;
        expDone = 1'b0;
        @(negedge clk);
        check("reset_w_en", w_en, 0);
        check("reset_cpu_rst", cpu_rst, 1);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_w_addr", w_addr, 0);
        check("reset_din", din, 0);
    endtask

    task automatic finalCheck(string tag);
        check({tag, "_error"}, error, expErr);
        check({tag, "_done"}, done, expDone);
        check({tag, "_cpu_rst"}, cpu_rst, !expDone);
        check({tag, "_pending_writes"}, expQ.size(), 0);
    endtask

    always @(negedge clk) begin
        check("cpu_rst_vs_done", cpu_rst, !done);
        if (w_en) begin
            wr_t wr;
            check("w_en_back_to_back", prevWen, 0);
            check("w_en_expected", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
                wr = expQ.pop_front();
                check("w_addr", w_addr, wr.addr);
                check("din", din, wr.data);
            end
        end
        prevWen = w_en;
    end

    initial begin
        logic [15:0] len16;
        int          r;
        int          nWords;

        doReset();
        addByte(8'h02, 1); addByte(8'h00, 1); addByte(8'h34, 1);
        addByte(8'h12, 1); addByte(8'hCD, 1); addByte(8'hAB, 1);
        runModel();
        check("pin_two_word_count", expQ.size(), 2);
        check("pin_two_word_w0", expQ[0].data, 16'h1234);
        check("pin_two_word_a1", expQ[1].addr, 1);
        check("pin_two_word_w1", expQ[1].data, 16'hABCD);
        check("pin_two_word_done", expDone, 1);
        sendStream();
        finalCheck("two_word");

        doReset();
        addByte(8'h00, 1); addByte(8'h00, 1);
        runModel();
        check("pin_zero_len_done", expDone, 1);
        sendStream();
        finalCheck("zero_len");

        doReset();
        addByte(8'h01, 1); addByte(8'h11, 1);
        runModel();
        check("pin_over_len_error", expErr, 1);
        sendStream();
        finalCheck("over_len");

        doReset();
        addByte(8'h02, 1); addByte(8'h00, 1); addByte(8'h55, 0);
        addByte(8'h01, 1); addByte(8'h00, 1); addByte(8'hEF, 1); addByte(8'hBE, 1);
        runModel();
        check("pin_frame_count", expQ.size(), 1);
        check("pin_frame_w0", expQ[0].data, 16'hBEEF);
        check("pin_frame_error", expErr, 1);
        sendStream();
        finalCheck("frame_err");

        doReset();
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_done", done, 0);
        check("glitch_error", error, 0);
        addByte(8'h01, 1); addByte(8'h00, 1); addByte(8'h78, 1); addByte(8'h56, 1);
        runModel();
        sendStream();
        finalCheck("after_glitch");

        doReset();
        addByte(8'h04, 1); addByte(8'h00, 1); addByte(8'h11, 1);
        runModel();
        sendStream();
        check("mid_load_done", done, 0);
        doReset();
        for (int i = 0; i < 4; i++) begin
            addByte(8'(8'h10 + i), 1);
            addByte(8'(8'hA0 + i), 1);
        end
        txBytes.push_front(8'h00); txOk.push_front(1);
        txBytes.push_front(8'h04); txOk.push_front(1);
        runModel();
        check("pin_reload_count", expQ.size(), 4);
        sendStream();
        finalCheck("reload");

        doReset();
        addByte(8'(MAXW), 1); addByte(8'h00, 1);
        for (int i = 0; i < 2 * MAXW; i++) addByte(8'($urandom_range(0, 255)), 1);
        runModel();
        check("pin_max_len_count", expQ.size(), MAXW);
        sendStream();
        finalCheck("max_len");

        doReset();
        addByte(8'(MAXW + 1), 1); addByte(8'h00, 1); addByte(8'h12, 1); addByte(8'h34, 1);
        runModel();
        sendStream();
        finalCheck("max_plus_one");

        for (int s = 0; s < 8; s++) begin
            doReset();
            r = $urandom_range(0, 9);
            if (r == 0) len16 = 16'd0;
            else if (r == 1) len16 = 16'($urandom_range(MAXW + 1, 65535));
            else len16 = 16'($urandom_range(1, MAXW));
            addByte(len16[7:0], 1);
            addByte(len16[15:8], 1);
            nWords = (int'(len16) > MAXW) ? 1 : int'(len16);
            for (int i = 0; i < 2 * nWords; i++) addByte(8'($urandom_range(0, 255)), 1);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) addByte(8'($urandom_range(0, 255)), 1);
            if ($urandom_range(0, 3) == 0) txOk[$urandom_range(0, txOk.size() - 1)] = 1'b0;
            runModel();
            sendStream();
            finalCheck("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
